// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler: collects MSB-first or LSB-first bit streams
// into DATA_WIDTH-bit words, with one word of buffering behind the output register.
module serial_word_assembler #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  msb_first,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         pos;
  logic                  order_q;
  logic                  order;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word_next;
  logic [DATA_WIDTH-1:0] pend_word;
  logic                  pending;
  logic                  accept;
  logic                  complete;
  logic                  slot_free;

  // Bit order is taken live on the first bit of a word, then from the latch.
  always_comb begin
    din_ready      = !pending;
    accept         = din_valid && din_ready;
    order          = (cnt == '0) ? msb_first : order_q;
    pos            = order ? (LAST - cnt) : cnt;
    word_next      = (cnt == '0) ? '0 : shreg;
    word_next[pos] = din;
    complete       = accept && (cnt == LAST);
    slot_free      = !dout_valid || dout_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      order_q    <= 1'b0;
      shreg      <= '0;
      pend_word  <= '0;
      pending    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (accept) begin
        shreg <= word_next;
        cnt   <= complete ? '0 : cnt + 1'b1;
        if (cnt == '0)
          order_q <= msb_first;
      end
      // While pending, din_ready is low so no word can complete in this branch.
      if (pending) begin
        if (dout_valid && dout_ready) begin
          dout    <= pend_word;
          pending <= 1'b0;
        end
      end else if (complete) begin
        if (slot_free) begin
          dout       <= word_next;
          dout_valid <= 1'b1;
        end else begin
          pend_word <= word_next;
          pending   <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Self-checking bench for serial_word_assembler (DATA_WIDTH = 8): directed
// scenarios plus a randomized run against a queue-based reference model.
module tb_serial_word_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       msb_first;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  int checks   = 0;
  int failures = 0;

  serial_word_assembler #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .msb_first  (msb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; msb_first = 1'b1; dout_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected %h", dout, 8'h00); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
  endtask

  task automatic test_msb_first();
    logic [7:0] pat;
    pat = 8'hB1;
    dout_ready = 1'b1; msb_first = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din_valid = 1'b1; din = pat[7-k];
      step();
      if (k < 7) begin
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL msb_early_valid: bit %0d got %b expected 0", k, dout_valid); end
      end
    end
    din_valid = 1'b0;
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL msb_valid: got %b expected 1", dout_valid); end
    checks++; if (dout !== 8'hB1) begin failures++; $display("FAIL msb_dout: got %h expected %h", dout, 8'hB1); end
    step();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL msb_valid_one_cycle: got %b expected 0", dout_valid); end
    checks++; if (dout !== 8'hB1) begin failures++; $display("FAIL msb_dout_hold: got %h expected %h", dout, 8'hB1); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    pat = 8'hB1;
    dout_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      msb_first = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (t == 1 && k >= 3) msb_first = 1'b1;
        din_valid = 1'b1; din = pat[7-k];
        step();
      end
      din_valid = 1'b0;
      checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid: pass %0d got %b expected 1", t, dout_valid); end
      checks++; if (dout !== 8'h8D) begin failures++; $display("FAIL lsb_dout: pass %0d got %h expected %h", t, dout, 8'h8D); end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [2];
    words[0] = 8'hB1; words[1] = 8'h0F;
    dout_ready = 1'b0; msb_first = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1; din = words[i/8][7-(i%8)];
      step();
      if (i >= 7) begin
        checks++; if (dout !== 8'hB1 || dout_valid !== 1'b1) begin failures++; $display("FAIL bp_hold: bit %0d got %h/%b expected %h/1", i, dout, dout_valid, 8'hB1); end
      end
      checks++; if (din_ready !== (i == 15 ? 1'b0 : 1'b1)) begin failures++; $display("FAIL bp_din_ready: bit %0d got %b expected %b", i, din_ready, (i == 15 ? 1'b0 : 1'b1)); end
    end
    for (int c = 0; c < 2; c++) begin
      din_valid = 1'b1; din = 1'($urandom_range(0, 1)); msb_first = 1'($urandom_range(0, 1));
      step();
      checks++; if (dout !== 8'hB1 || dout_valid !== 1'b1) begin failures++; $display("FAIL bp_stall_hold: got %h/%b expected %h/1", dout, dout_valid, 8'hB1); end
      checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready: got %b expected 0", din_ready); end
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    checks++; if (dout !== 8'h0F) begin failures++; $display("FAIL bp_pending_dout: got %h expected %h", dout, 8'h0F); end
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL bp_pending_valid: got %b expected 1", dout_valid); end
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return: got %b expected 1", din_ready); end
    dout_ready = 1'b1;
    step();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b expected 0", dout_valid); end
  endtask

  task automatic test_gaps();
    logic [7:0] pat;
    pat = 8'h5A;
    dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) begin
        din_valid = 1'b0; din = 1'($urandom_range(0, 1)); msb_first = 1'($urandom_range(0, 1));
        step();
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL gap_idle_valid: bit %0d got %b expected 0", k, dout_valid); end
      end
      din_valid = 1'b1; din = pat[7-k];
      msb_first = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
    end
    din_valid = 1'b0;
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL gap_valid: got %b expected 1", dout_valid); end
    checks++; if (dout !== 8'h5A) begin failures++; $display("FAIL gap_dout: got %h expected %h", dout, 8'h5A); end
    step();
  endtask

  task automatic test_reset_midword();
    logic [7:0] pat;
    pat = 8'h3C;
    dout_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din_valid = 1'b1; din = 1'($urandom_range(0, 1)); msb_first = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b1; din_valid = 1'b0;
    step();
    reset = 1'b0; msb_first = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din_valid = 1'b1; din = pat[7-k];
      step();
    end
    din_valid = 1'b0; dout_ready = 1'b0;
    checks++; if (dout !== 8'h3C || dout_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_dout: got %h/%b expected %h/1", dout, dout_valid, 8'h3C); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL rst_held_valid: got %b expected 0", dout_valid); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rst_held_dout: got %h expected %h", dout, 8'h00); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    logic       ord   [4];
    for (int i = 0; i < 4; i++) begin
      words[i] = 8'($urandom); ord[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) begin
        din_valid = 1'b1; msb_first = ord[i];
        din = words[i][ord[i] ? 7-k : k];
        dout_ready = (k == 7);
        step();
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL b2b_din_ready: word %0d bit %0d got %b expected 1", i, k, din_ready); end
        if (k == 7) begin
          checks++; if (dout !== words[i] || dout_valid !== 1'b1) begin failures++; $display("FAIL b2b_word: word %0d got %h/%b expected %h/1", i, dout, dout_valid, words[i]); end
        end else if (i > 0) begin
          checks++; if (dout !== words[i-1] || dout_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold: word %0d bit %0d got %h/%b expected %h/1", i, k, dout, dout_valid, words[i-1]); end
        end
      end
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    step();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", dout_valid); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] acc;
    logic [7:0] shown;
    logic       ord;
    int         nb;
    logic       take;
    reset = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    step();
    reset = 1'b0;
    q.delete(); nb = 0; acc = '0; ord = 1'b0; shown = '0;
    for (int c = 0; c < 400; c++) begin
      din_valid  = ($urandom_range(0, 3) != 0);
      din        = 1'($urandom_range(0, 1));
      msb_first  = 1'($urandom_range(0, 1));
      dout_ready = ($urandom_range(0, 2) == 0);
      take = din_valid && (q.size() < 2);
      if (q.size() > 0 && dout_ready) void'(q.pop_front());
      if (take) begin
        if (nb == 0) begin ord = msb_first; acc = '0; end
        acc[ord ? 7-nb : nb] = din;
        nb++;
        if (nb == 8) begin q.push_back(acc); nb = 0; end
      end
      step();
      if (q.size() > 0) shown = q[0];
      checks++; if (dout_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", c, dout_valid, (q.size() > 0)); end
      checks++; if (din_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_din_ready: cycle %0d got %b expected %b", c, din_ready, (q.size() < 2)); end
      checks++; if (dout !== shown) begin failures++; $display("FAIL rnd_dout: cycle %0d got %h expected %h", c, dout, shown); end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_gaps();
    test_reset_midword();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Receive side of the team's bit-order path: collects a 1-bit serial stream into DATA_WIDTH-bit words.
- Each word can arrive MSB-first or LSB-first. The block places every bit in its true position, so the output is never bit-reversed.
- Serial input uses a valid/ready handshake; parallel output uses a valid/ready handshake.
- Sits between a serial link front-end and word-wide datapath logic.

Parameters:
- DATA_WIDTH, 32, word width in bits; legal range ≥ 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din carries a bit this cycle.
- din_ready  output  1  block accepts a bit this cycle.
- msb_first  input  1  bit order of the word being started: 1 = MSB-first, 0 = LSB-first.
- dout  output  DATA_WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  downstream consumes dout this cycle.

Behaviour:
- Reset (sync, active-high, priority over all else):
  - dout = 0, dout_valid = 0, din_ready = 1.
  - Bit counter = 0, pending flag = 0, shift register = 0.
  - Reset mid-word discards the partial word; reset with dout_valid = 1 drops the held word.
- Bit accept:
  - A bit is accepted when din_valid && din_ready.
  - din_ready = !pending; it is combinational from registered state only, with no path from din_valid or dout_ready.
- Bit order:
  - msb_first is sampled only on the first accepted bit of a word (counter == 0) and latched for that word.
  - Changes to msb_first mid-word are ignored.
  - Accepted bit k (k = 0..DATA_WIDTH-1) of a word lands at position DATA_WIDTH-1-k if the latched order is 1, else at position k.
- Counter:
  - 0..DATA_WIDTH-1; increments per accepted bit.
  - Wraps to 0 on the accepted bit with counter == DATA_WIDTH-1 (word complete).
  - Idle cycles (din_valid = 0) do not change the counter or the shift register; gaps inside a word are legal.
- Output slot:
  - Slot is free this cycle iff !dout_valid || dout_ready.
  - Word complete and slot free: dout <= completed word and dout_valid <= 1 on that edge, so latency is 1 cycle from the last accepted bit.
  - Word complete and slot not free: the completed word is held internally, pending <= 1, and din_ready is 0 from the next cycle.
  - While pending, the first cycle with dout_valid && dout_ready loads the pending word into dout; dout_valid stays 1, pending <= 0, and din_ready returns to 1 the next cycle.
  - dout_valid && dout_ready with no word loading: dout_valid <= 0; dout keeps its last value.
- Simultaneous events:
  - Word completes in the same cycle dout is consumed: the new word loads, dout_valid stays 1, no stall, no pending.
  - Back-to-back words with dout_ready held at 1 sustain 1 bit/cycle with no bubbles.
- Output stability: dout and dout_valid never change while dout_valid = 1 and dout_ready = 0.
- Throughput: maximum 1 bit/cycle. At most 2 complete words are in flight (dout plus pending); while pending, din_ready = 0 blocks a third.

Test Plan:
1. DATA_WIDTH = 8, msb_first = 1, bits 1,0,1,1,0,0,0,1 on consecutive cycles, dout_ready = 1 -> dout = 8'hB1, dout_valid high one cycle after the 8th bit, for exactly 1 cycle.
2. Same bits with msb_first = 0 -> dout = 8'h8D. Toggle msb_first after bit 3 -> still 8'h8D (latched order).
3. Hold dout_ready = 0, send two words 8'hB1 then 8'h0F (MSB-first):
   - dout = 8'hB1 stays stable.
   - din_ready drops the cycle after the 16th bit.
   - Raise dout_ready for 1 cycle -> dout = 8'h0F, dout_valid stays 1, din_ready returns to 1.
4. Random din_valid gaps inside a word, 8'h5A MSB-first -> dout = 8'h5A; counter unaffected by idle cycles.
5. Assert reset after 5 bits, then send a full word 8'h3C -> dout = 8'h3C with no residue from the partial word. Reset while dout_valid = 1 -> dout_valid = 0, dout = 0 next cycle.
6. Continuous stream of 4 words with dout_ready = 1, last bit of each word coinciding with consumption of the previous word -> din_ready stays 1 throughout, all words are output in order with no drops.
